// File: rtl/swap_cmd_sequencer_if.sv
// Request/issue bus between the host, the swap command sequencer and the swap register file.
// The slave side is the sequencer itself; the master side is the host or testbench.
interface swap_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int FIFO_DEPTH = 4
);
    logic                          req_valid;
    logic                          req_ready;
    logic [ADDR_WIDTH-1:0]         req_addr_a;
    logic [ADDR_WIDTH-1:0]         req_addr_b;
    logic                          swap;
    logic [ADDR_WIDTH-1:0]         address_A;
    logic [ADDR_WIDTH-1:0]         address_B;
    logic                          busy;
    logic                          done;
    logic [$clog2(FIFO_DEPTH):0]   level;

    modport master (
        output req_valid, req_addr_a, req_addr_b,
        input  req_ready, swap, address_A, address_B, busy, done, level
    );

    modport slave (
        input  req_valid, req_addr_a, req_addr_b,
        output req_ready, swap, address_A, address_B, busy, done, level
    );
endinterface

// File: rtl/swap_cmd_sequencer.sv
// Queues swap address pairs and issues them one at a time to the swap FSM.
// The addresses are held from the pop edge until the next pop.
module swap_cmd_sequencer #(
    parameter int ADDR_WIDTH  = 7,
    parameter int FIFO_DEPTH  = 4,
    parameter int SWAP_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    swap_cmd_sequencer_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(SWAP_CYCLES) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [ADDR_WIDTH-1:0] mem_a_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_b_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;

    logic                  push, pop, fifo_empty, fifo_full;
    logic [ADDR_WIDTH-1:0] head_a, head_b;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign push       = bus.req_valid && !fifo_full;
    assign head_a     = mem_a_q[rd_ptr_q];
    assign head_b     = mem_b_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= bus.req_addr_a;
            mem_b_q[wr_ptr_q] <= bus.req_addr_b;
        end
    end

    // A head with equal addresses is popped without issuing; WAIT defers it to IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_a != head_b) begin
                        addr_a_d = head_a;
                        addr_b_d = head_b;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(SWAP_CYCLES - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty && (head_a != head_b)) begin
                        pop      = 1'b1;
                        addr_a_d = head_a;
                        addr_b_d = head_b;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.swap      = (state_q == ST_ISSUE);
    assign bus.busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign bus.done      = (state_q == ST_WAIT) && (cnt_q == '0);
    assign bus.address_A = addr_a_q;
    assign bus.address_B = addr_b_q;
    assign bus.level     = level_q;
endmodule

// File: tb/tb_swap_cmd_sequencer.sv
// Directed bench for swap_cmd_sequencer: reset, single, back-to-back, full FIFO,
// degenerate a==b request and reset during a swap.
module tb_swap_cmd_sequencer;
    localparam int AW = 7;
    localparam int DEPTH = 4;
    localparam int SC = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    int   sw_a[$];
    int   sw_b[$];
    int   sw_cyc[$];

    swap_cmd_sequencer_if #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

    swap_cmd_sequencer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .SWAP_CYCLES(SC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every issued swap and done pulse mid-cycle.
    always @(negedge clk) begin
        if (bus.swap === 1'b1) begin
            sw_a.push_back(int'(bus.address_A));
            sw_b.push_back(int'(bus.address_B));
            sw_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        sw_a.delete();
        sw_b.delete();
        sw_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic drive(input logic v, input int a, input int b);
        bus.req_valid  = v;
        bus.req_addr_a = AW'(a);
        bus.req_addr_b = AW'(b);
    endtask

    initial begin
        // Reset held with a request presented
        drive(1'b1, 3, 4);
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_ready", bus.req_ready, 1);
        check("rst_level", bus.level, 0);
        check("rst_swap",  bus.swap, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_addrA", bus.address_A, 0);
        check("rst_addrB", bus.address_B, 0);
        drive(1'b0, 0, 0);
        reset_n = 1'b1;
        tick();
        clear_log();

        // Single swap (5,9)
        drive(1'b1, 5, 9);
        tick();
        drive(1'b0, 0, 0);
        check("single_level_push", bus.level, 1);
        check("single_swap_early", bus.swap, 0);
        tick();
        check("single_swap",  bus.swap, 1);
        check("single_busy1", bus.busy, 1);
        check("single_A1",    bus.address_A, 5);
        check("single_B1",    bus.address_B, 9);
        check("single_level_pop", bus.level, 0);
        tick();
        check("single_swap_off", bus.swap, 0);
        check("single_busy2",    bus.busy, 1);
        check("single_done2",    bus.done, 0);
        tick();
        check("single_done3", bus.done, 0);
        check("single_A3",    bus.address_A, 5);
        tick();
        check("single_done4", bus.done, 1);
        check("single_busy4", bus.busy, 1);
        check("single_B4",    bus.address_B, 9);
        tick();
        check("single_busy_end", bus.busy, 0);
        check("single_done_end", bus.done, 0);
        check("single_A_hold",   bus.address_A, 5);
        check("single_swaps",    sw_a.size(), 1);
        check("single_dones",    done_cnt, 1);
        clear_log();

        // Back-to-back (1,2),(3,4),(6,7)
        drive(1'b1, 1, 2); tick();
        drive(1'b1, 3, 4); tick();
        drive(1'b1, 6, 7); tick();
        drive(1'b0, 0, 0);
        repeat (16) tick();
        check("b2b_swaps", sw_a.size(), 3);
        check("b2b_dones", done_cnt, 3);
        if (sw_a.size() == 3) begin
            check("b2b_A0", sw_a[0], 1);
            check("b2b_B0", sw_b[0], 2);
            check("b2b_A1", sw_a[1], 3);
            check("b2b_B1", sw_b[1], 4);
            check("b2b_A2", sw_a[2], 6);
            check("b2b_B2", sw_b[2], 7);
            check("b2b_gap1", sw_cyc[1] - sw_cyc[0], 4);
            check("b2b_gap2", sw_cyc[2] - sw_cyc[1], 4);
        end
        check("b2b_A_hold", bus.address_A, 6);
        check("b2b_B_hold", bus.address_B, 7);
        clear_log();

        // Full FIFO: six requests back to back, the sixth meets a full FIFO
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 10 + i, 20 + i);
            tick();
            if (i == 4) begin
                check("full_ready", bus.req_ready, 0);
                check("full_level", bus.level, 4);
            end
        end
        drive(1'b0, 0, 0);
        check("full_level_after", bus.level, 3);
        repeat (30) tick();
        check("full_swaps", sw_a.size(), 5);
        check("full_dones", done_cnt, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < sw_a.size()) begin
                check($sformatf("full_A%0d", k), sw_a[k], 10 + k);
                check($sformatf("full_B%0d", k), sw_b[k], 20 + k);
            end
        end
        check("full_level_end", bus.level, 0);
        clear_log();

        // Degenerate (8,8) then (2,3)
        drive(1'b1, 8, 8); tick();
        drive(1'b1, 2, 3); tick();
        drive(1'b0, 0, 0);
        check("degen_noswap", bus.swap, 0);
        check("degen_level",  bus.level, 1);
        check("degen_A_keep", bus.address_A, 14);
        tick();
        check("degen_swap", bus.swap, 1);
        check("degen_A",    bus.address_A, 2);
        check("degen_B",    bus.address_B, 3);
        repeat (8) tick();
        check("degen_swaps", sw_a.size(), 1);
        check("degen_dones", done_cnt, 1);
        clear_log();

        // Reset while in WAIT with two requests queued
        drive(1'b1, 30, 31); tick();
        drive(1'b1, 32, 33); tick();
        drive(1'b1, 34, 35); tick();
        drive(1'b0, 0, 0);
        check("mid_busy_pre",  bus.busy, 1);
        check("mid_level_pre", bus.level, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_busy",  bus.busy, 0);
        check("mid_level", bus.level, 0);
        check("mid_A",     bus.address_A, 0);
        check("mid_B",     bus.address_B, 0);
        check("mid_ready", bus.req_ready, 1);
        clear_log();
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("mid_swaps_after", sw_a.size(), 0);
        check("mid_dones_after", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
